// File: rtl/cache_port_arb_if.sv
// Avalon-MM port bundle used on both sides of the cache port arbiter.
// master drives the request; slave returns stall and read response.
interface cache_port_arb_if;
   logic [31:0] address;
   logic [3:0]  byteEnable;
   logic        read;
   logic        write;
   logic [31:0] writeData;
   logic        waitRequest;
   logic [31:0] readData;
   logic        readDataValid;

   modport master (
      output address, byteEnable, read, write, writeData,
      input  waitRequest, readData, readDataValid
   );

   modport slave (
      input  address, byteEnable, read, write, writeData,
      output waitRequest, readData, readDataValid
   );
endinterface

// File: rtl/cache_port_arb.sv
// Round-robin two-master arbiter for the cache CPU port, with a hold-while-stalled
// lock and an in-order owner FIFO that routes pipelined read responses to their issuer.
module cache_port_arb #(
   parameter int unsigned MAX_PENDING = 4
) (
   input  logic              clk,
   input  logic              rest,
   cache_port_arb_if.slave   s0,
   cache_port_arb_if.slave   s1,
   cache_port_arb_if.master  m0,
   output logic              err_orphanRsp
);

   localparam int unsigned PW = $clog2(MAX_PENDING);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e;

   arb_state_e    state_q;
   logic          lock_sel_q;
   logic          last_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic          owner_q [MAX_PENDING];
   logic          err_q;

   logic full, elig0, elig1;
   logic gnt, sel, go;
   logic sel_read, sel_write;
   logic accept, push, pop, has_pending, head;

   // A read that cannot get a FIFO slot is not a request at all; read wins over write.
   assign full  = (cnt_q == CW'(MAX_PENDING));
   assign elig0 = s0.read ? ~full : s0.write;
   assign elig1 = s1.read ? ~full : s1.write;

   always_comb begin
      sel = 1'b0;
      gnt = 1'b0;
      if (state_q == ARB_LOCKED) begin
         sel = lock_sel_q;
         gnt = lock_sel_q ? elig1 : elig0;
      end else if (elig0 && elig1) begin
         sel = ~last_q;
         gnt = 1'b1;
      end else if (elig0 || elig1) begin
         sel = elig1;
         gnt = 1'b1;
      end
   end

   assign go        = gnt & ~rest;
   assign sel_read  = sel ? s1.read  : s0.read;
   assign sel_write = sel ? s1.write : s0.write;

   assign m0.read       = go & sel_read;
   assign m0.write      = go & sel_write & ~sel_read;
   assign m0.address    = sel ? s1.address    : s0.address;
   assign m0.byteEnable = sel ? s1.byteEnable : s0.byteEnable;
   assign m0.writeData  = sel ? s1.writeData  : s0.writeData;

   assign s0.waitRequest = ~(go & ~sel) | m0.waitRequest;
   assign s1.waitRequest = ~(go &  sel) | m0.waitRequest;

   assign accept      = (m0.read | m0.write) & ~m0.waitRequest;
   assign push        = accept & m0.read;
   assign has_pending = (cnt_q != '0);
   assign pop         = m0.readDataValid & has_pending & ~rest;
   assign head        = owner_q[rd_ptr_q];

   assign s0.readDataValid = pop & ~head;
   assign s1.readDataValid = pop &  head;
   assign s0.readData      = m0.readData;
   assign s1.readData      = m0.readData;
   assign err_orphanRsp    = err_q;

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + CW'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         state_q    <= ARB_OPEN;
         lock_sel_q <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         // A granted-but-stalled transfer pins the grant; any other outcome reopens arbitration.
         if (accept) begin
            state_q <= ARB_OPEN;
            last_q  <= sel;
         end else if (gnt) begin
            state_q    <= ARB_LOCKED;
            lock_sel_q <= sel;
         end else begin
            state_q <= ARB_OPEN;
         end
         if (push) begin
            owner_q[wr_ptr_q] <= sel;
            wr_ptr_q          <= wr_ptr_q + PW'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q <= cnt_d;
         if (m0.readDataValid && !has_pending)
            err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_port_arb.sv
// Self-checking bench for cache_port_arb: directed vector table, hand sequences for
// lock/full/reset corners, and randomized traffic against a queue-based reference model.
module tb_cache_port_arb;

   localparam int unsigned MAXP = 4;

   logic clk;
   logic rest;
   logic err_orphanRsp;

   cache_port_arb_if s0_bus ();
   cache_port_arb_if s1_bus ();
   cache_port_arb_if m0_bus ();

   cache_port_arb #(.MAX_PENDING(MAXP)) dut (
      .clk           (clk),
      .rest          (rest),
      .s0            (s0_bus.slave),
      .s1            (s1_bus.slave),
      .m0            (m0_bus.master),
      .err_orphanRsp (err_orphanRsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // reference model state: owners held as a plain in-order queue
   int unsigned owners[$];
   bit          m_lock;
   int unsigned m_lock_sel;
   int unsigned m_last;
   bit          m_err;

   typedef struct {
      logic        s0r, s0w, s1r, s1w, wt, rdv;
      logic [31:0] rdata;
      logic        xm0r, xm0w;
      logic [31:0] xaddr;
      logic        xs0wait, xs1wait, xs0v, xs1v;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drv(input logic s0r, s0w, s1r, s1w, wt, rdv);
      s0_bus.read = s0r; s0_bus.write = s0w;
      s1_bus.read = s1r; s1_bus.write = s1w;
      m0_bus.waitRequest = wt; m0_bus.readDataValid = rdv;
   endtask

   function automatic void pick(output bit g, output int unsigned s);
      bit e0, e1;
      e0 = s0_bus.read ? (owners.size() < MAXP) : s0_bus.write;
      e1 = s1_bus.read ? (owners.size() < MAXP) : s1_bus.write;
      if (m_lock) begin
         s = m_lock_sel;
         g = (s == 1) ? e1 : e0;
      end else begin
         g = e0 | e1;
         if (e0 && e1) s = 1 - m_last;
         else          s = e1 ? 1 : 0;
      end
   endfunction

   task automatic model_check();
      bit g;
      int unsigned s;
      bit rd, wr, xr, xw, v0, v1;
      pick(g, s);
      rd = (s == 1) ? s1_bus.read  : s0_bus.read;
      wr = (s == 1) ? s1_bus.write : s0_bus.write;
      xr = !rest && g && rd;
      xw = !rest && g && wr && !rd;
      v0 = !rest && m0_bus.readDataValid && owners.size() > 0 && owners[0] == 0;
      v1 = !rest && m0_bus.readDataValid && owners.size() > 0 && owners[0] == 1;
      chk("m0_read", m0_bus.read, xr);
      chk("m0_write", m0_bus.write, xw);
      if (xr || xw) begin
         chk("m0_address", m0_bus.address, (s == 1) ? s1_bus.address : s0_bus.address);
         chk("m0_writeData", m0_bus.writeData, (s == 1) ? s1_bus.writeData : s0_bus.writeData);
         chk("m0_byteEnable", m0_bus.byteEnable, (s == 1) ? s1_bus.byteEnable : s0_bus.byteEnable);
      end
      chk("s0_waitRequest", s0_bus.waitRequest, rest || !(g && s == 0) || m0_bus.waitRequest);
      chk("s1_waitRequest", s1_bus.waitRequest, rest || !(g && s == 1) || m0_bus.waitRequest);
      chk("s0_readDataValid", s0_bus.readDataValid, v0);
      chk("s1_readDataValid", s1_bus.readDataValid, v1);
      chk("s1_readData", s1_bus.readData, m0_bus.readData);
      chk("err_orphanRsp", err_orphanRsp, m_err);
   endtask

   task automatic model_update();
      bit g;
      int unsigned s;
      bit rd, wr, acc;
      int unsigned pre;
      if (rest) begin
         owners.delete();
         m_lock = 0; m_last = 1; m_err = 0; m_lock_sel = 0;
         return;
      end
      pick(g, s);
      rd  = (s == 1) ? s1_bus.read  : s0_bus.read;
      wr  = (s == 1) ? s1_bus.write : s0_bus.write;
      acc = g && (rd || wr) && !m0_bus.waitRequest;
      pre = owners.size();
      if (m0_bus.readDataValid) begin
         if (pre > 0) void'(owners.pop_front());
         else         m_err = 1;
      end
      if (acc) begin
         m_last = s;
         m_lock = 0;
         if (rd) owners.push_back(s);
      end else if (g) begin
         m_lock = 1;
         m_lock_sel = s;
      end else begin
         m_lock = 0;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_check();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick();
      settle();
      adv();
   endtask

   task automatic do_reset();
      rest = 1'b1;
      drv(1, 1, 1, 0, 0, 1);
      settle();
      chk("rst_m0_read", m0_bus.read, 1'b0);
      chk("rst_s0_wait", s0_bus.waitRequest, 1'b1);
      chk("rst_s0_rdv", s0_bus.readDataValid, 1'b0);
      adv();
      tick();
      rest = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      settle();
      chk("rst_err_clear", err_orphanRsp, 1'b0);
      adv();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1,0,1,0,0,0, 32'h0, 1,0, 32'h100, 0,1,0,0};
      tbl[1] = '{0,0,1,0,0,0, 32'h0, 1,0, 32'h200, 1,0,0,0};
      tbl[2] = '{0,0,0,0,0,1, 32'hA, 0,0, 32'h0,   1,1,1,0};
      tbl[3] = '{0,0,0,0,0,1, 32'hB, 0,0, 32'h0,   1,1,0,1};
      tbl[4] = '{0,0,0,0,0,0, 32'h0, 0,0, 32'h0,   1,1,0,0};
      tbl[5] = '{0,1,0,1,0,0, 32'h0, 0,1, 32'h100, 0,1,0,0};
      tbl[6] = '{0,1,0,1,0,0, 32'h0, 0,1, 32'h200, 1,0,0,0};

      rest = 1'b1;
      s0_bus.address = 32'h100; s0_bus.byteEnable = 4'hF; s0_bus.writeData = 32'h1111;
      s1_bus.address = 32'h200; s1_bus.byteEnable = 4'h3; s1_bus.writeData = 32'hDEAD;
      m0_bus.readData = '0;
      drv(0, 0, 0, 0, 0, 0);
      owners.delete();
      m_lock = 0; m_last = 1; m_err = 0; m_lock_sel = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // directed table: round-robin reads, in-order routing, write tie-break
      for (int unsigned i = 0; i < 7; i++) begin
         drv(tbl[i].s0r, tbl[i].s0w, tbl[i].s1r, tbl[i].s1w, tbl[i].wt, tbl[i].rdv);
         m0_bus.readData = tbl[i].rdata;
         settle();
         chk($sformatf("tbl%0d_m0_read", i), m0_bus.read, tbl[i].xm0r);
         chk($sformatf("tbl%0d_m0_write", i), m0_bus.write, tbl[i].xm0w);
         if (tbl[i].xm0r || tbl[i].xm0w)
            chk($sformatf("tbl%0d_m0_address", i), m0_bus.address, tbl[i].xaddr);
         chk($sformatf("tbl%0d_s0_wait", i), s0_bus.waitRequest, tbl[i].xs0wait);
         chk($sformatf("tbl%0d_s1_wait", i), s1_bus.waitRequest, tbl[i].xs1wait);
         chk($sformatf("tbl%0d_s0_rdv", i), s0_bus.readDataValid, tbl[i].xs0v);
         chk($sformatf("tbl%0d_s1_rdv", i), s1_bus.readDataValid, tbl[i].xs1v);
         chk($sformatf("tbl%0d_s0_rdata", i), s0_bus.readData, tbl[i].rdata);
         adv();
      end

      // stalled s1 write holds the grant against a pending s0 read
      do_reset();
      drv(0, 0, 0, 1, 1, 0);
      settle();
      chk("lock_first_m0_write", m0_bus.write, 1'b1);
      chk("lock_first_s1_wait", s1_bus.waitRequest, 1'b1);
      adv();
      drv(1, 0, 0, 1, 1, 0);
      repeat (2) begin
         settle();
         chk("lock_hold_addr", m0_bus.address, 32'h200);
         chk("lock_hold_wdata", m0_bus.writeData, 32'hDEAD);
         chk("lock_hold_s0_wait", s0_bus.waitRequest, 1'b1);
         adv();
      end
      drv(1, 0, 0, 1, 0, 0);
      settle();
      chk("lock_accept_m0_write", m0_bus.write, 1'b1);
      chk("lock_accept_s0_wait", s0_bus.waitRequest, 1'b1);
      adv();
      drv(1, 0, 0, 0, 0, 0);
      settle();
      chk("lock_after_m0_read", m0_bus.read, 1'b1);
      chk("lock_after_addr", m0_bus.address, 32'h100);
      chk("lock_after_s0_wait", s0_bus.waitRequest, 1'b0);
      adv();

      // full owner FIFO blocks a 5th read but not a write from the other master
      do_reset();
      drv(1, 0, 0, 0, 0, 0);
      repeat (4) tick();
      drv(1, 0, 0, 1, 0, 0);
      settle();
      chk("full_s0_wait", s0_bus.waitRequest, 1'b1);
      chk("full_m0_read", m0_bus.read, 1'b0);
      chk("full_m0_write", m0_bus.write, 1'b1);
      chk("full_write_addr", m0_bus.address, 32'h200);
      adv();
      drv(1, 0, 0, 0, 0, 1);
      m0_bus.readData = 32'h55;
      settle();
      chk("full_pop_s0_rdv", s0_bus.readDataValid, 1'b1);
      chk("full_pop_s0_wait", s0_bus.waitRequest, 1'b1);
      adv();
      drv(1, 0, 0, 0, 0, 0);
      settle();
      chk("full_freed_m0_read", m0_bus.read, 1'b1);
      chk("full_freed_s0_wait", s0_bus.waitRequest, 1'b0);
      adv();
      drv(0, 0, 0, 0, 0, 1);
      repeat (4) tick();

      // push and pop in the same cycle keep owners in order; then an orphan beat
      do_reset();
      drv(1, 0, 1, 0, 0, 0);
      repeat (2) tick();
      drv(1, 0, 0, 0, 0, 1);
      settle();
      chk("pp_s0_rdv", s0_bus.readDataValid, 1'b1);
      chk("pp_m0_read", m0_bus.read, 1'b1);
      adv();
      drv(0, 0, 0, 0, 0, 1);
      settle();
      chk("pp_next_s1_rdv", s1_bus.readDataValid, 1'b1);
      chk("pp_next_s0_rdv", s0_bus.readDataValid, 1'b0);
      adv();
      settle();
      chk("pp_last_s0_rdv", s0_bus.readDataValid, 1'b1);
      adv();
      settle();
      chk("orphan_s0_rdv", s0_bus.readDataValid, 1'b0);
      chk("orphan_s1_rdv", s1_bus.readDataValid, 1'b0);
      adv();
      drv(0, 0, 0, 0, 0, 0);
      repeat (3) begin
         settle();
         chk("orphan_err_sticky", err_orphanRsp, 1'b1);
         adv();
      end

      // reset with reads pending turns later responses into orphans
      do_reset();
      drv(1, 0, 0, 0, 0, 0);
      repeat (3) tick();
      rest = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      tick();
      rest = 1'b0;
      drv(0, 0, 0, 0, 0, 1);
      settle();
      chk("stale_err_before", err_orphanRsp, 1'b0);
      chk("stale_s0_rdv", s0_bus.readDataValid, 1'b0);
      adv();
      drv(0, 0, 0, 0, 0, 0);
      settle();
      chk("stale_err_after", err_orphanRsp, 1'b1);
      adv();

      // randomized traffic against the reference model
      do_reset();
      for (int unsigned c = 0; c < 3000; c++) begin
         rest = ($urandom_range(0, 199) == 0);
         s0_bus.read  = ($urandom_range(0, 99) < 40);
         s0_bus.write = ($urandom_range(0, 99) < 25);
         s1_bus.read  = ($urandom_range(0, 99) < 40);
         s1_bus.write = ($urandom_range(0, 99) < 25);
         s0_bus.address = $urandom; s0_bus.writeData = $urandom; s0_bus.byteEnable = 4'($urandom);
         s1_bus.address = $urandom; s1_bus.writeData = $urandom; s1_bus.byteEnable = 4'($urandom);
         m0_bus.waitRequest   = ($urandom_range(0, 99) < 30);
         m0_bus.readDataValid = ($urandom_range(0, 99) < 30);
         m0_bus.readData      = $urandom;
         tick();
      end
      rest = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
